// File: rtl/regfile_bypass.sv
// Multi-write-port register file with same-cycle write-to-read bypass,
// prioritised writeback (port0 > port1 > link save), busy scoreboard and collision flag.
module regfile_bypass #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int ZERO_R0  = 1,
  parameter int LINK_REG = (2**AW) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          rbusy0,
  output logic          rbusy1,
  output logic          rbusy2,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic          link_we,
  input  logic [31:0]   link_pc,
  input  logic          issue_v,
  input  logic [AW-1:0] issue_rd,
  output logic          wr_collide
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic             wr_collide_r;

  logic [31:0]      link_sum_s;
  logic [DW-1:0]    link_data_s;
  logic [DEPTH-1:0] wen_s;
  logic [DW-1:0]    wdat_s [DEPTH];
  logic [DEPTH-1:0] busy_nxt_s;
  logic             collide_s;
  logic [AW-1:0]    ra_s [3];
  logic [DW-1:0]    rd_s [3];
  logic [2:0]       rbusy_s;

  function automatic logic is_hardzero(input int idx);
    return (ZERO_R0 != 0) && (idx == 0);
  endfunction

  assign link_sum_s = link_pc + 32'd4;

  // Link data is the 32-bit PC+4 fitted to the data width
  generate
    if (DW > 32) begin : g_link_wide
      assign link_data_s = {{(DW-32){1'b0}}, link_sum_s};
    end else if (DW == 32) begin : g_link_eq
      assign link_data_s = link_sum_s;
    end else begin : g_link_narrow
      assign link_data_s = link_sum_s[DW-1:0];
    end
  endgenerate

  // Per-address write resolution and scoreboard next state
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wen_s[i]  = 1'b0;
      wdat_s[i] = '0;
      if (is_hardzero(i)) begin
        wen_s[i]  = 1'b0;
        wdat_s[i] = '0;
      end else if (we0 && (wa0 == AW'(i))) begin
        wen_s[i]  = 1'b1;
        wdat_s[i] = wd0;
      end else if (we1 && (wa1 == AW'(i))) begin
        wen_s[i]  = 1'b1;
        wdat_s[i] = wd1;
      end else if (link_we && (LINK_A == AW'(i))) begin
        wen_s[i]  = 1'b1;
        wdat_s[i] = link_data_s;
      end else begin
        wen_s[i]  = 1'b0;
        wdat_s[i] = '0;
      end

      // A new producer issuing outranks a writeback retiring the old one
      if (is_hardzero(i)) begin
        busy_nxt_s[i] = 1'b0;
      end else if (issue_v && (issue_rd == AW'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (wen_s[i]) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Two or more enabled writers aimed at one address, register 0 included
  always_comb begin
    collide_s = (we0 && we1 && (wa0 == wa1)) ||
                (we0 && link_we && (wa0 == LINK_A)) ||
                (we1 && link_we && (wa1 == LINK_A));
  end

  assign ra_s[0] = ra0;
  assign ra_s[1] = ra1;
  assign ra_s[2] = ra2;

  // Read ports: bypass pending writes unless in reset; busy is never bypassed
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_s[p]    = '0;
      rbusy_s[p] = 1'b0;
      if ((ZERO_R0 != 0) && (ra_s[p] == '0)) begin
        rd_s[p]    = '0;
        rbusy_s[p] = 1'b0;
      end else if (!rst && wen_s[ra_s[p]]) begin
        rd_s[p]    = wdat_s[ra_s[p]];
        rbusy_s[p] = busy_r[ra_s[p]];
      end else begin
        rd_s[p]    = mem_r[ra_s[p]];
        rbusy_s[p] = busy_r[ra_s[p]];
      end
    end
  end

  // Array, scoreboard and collision flag update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      busy_r       <= '0;
      wr_collide_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen_s[i]) begin
          mem_r[i] <= wdat_s[i];
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
      busy_r       <= busy_nxt_s;
      wr_collide_r <= collide_s;
    end
  end

  assign rd0        = rd_s[0];
  assign rd1        = rd_s[1];
  assign rd2        = rd_s[2];
  assign rbusy0     = rbusy_s[0];
  assign rbusy1     = rbusy_s[1];
  assign rbusy2     = rbusy_s[2];
  assign wr_collide = wr_collide_r;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass (AW=5, DW=32, ZERO_R0=1, LINK_REG=31).
module tb_regfile_bypass;

  logic        clk;
  logic        rst;
  logic [4:0]  ra0, ra1, ra2;
  logic [31:0] rd0, rd1, rd2;
  logic        rbusy0, rbusy1, rbusy2;
  logic        we0, we1, link_we, issue_v;
  logic [4:0]  wa0, wa1, issue_rd;
  logic [31:0] wd0, wd1, link_pc;
  logic        wr_collide;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_bypass #(.AW(5), .DW(32), .ZERO_R0(1), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst),
    .ra0(ra0), .ra1(ra1), .ra2(ra2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .rbusy0(rbusy0), .rbusy1(rbusy1), .rbusy2(rbusy2),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .link_we(link_we), .link_pc(link_pc),
    .issue_v(issue_v), .issue_rd(issue_rd),
    .wr_collide(wr_collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
    link_we = 1'b0; link_pc = 32'd0;
    issue_v = 1'b0; issue_rd = 5'd0;
  endtask

  // Move to the next falling edge: inputs change here, checks follow #1 later
  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1; ra0 = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    next(); next();
    rst = 1'b0;
    #1;

    // Reset state across every address
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i); ra2 = 5'(i);
      #1;
      chk("reset_rd0", rd0, 32'd0);
      chk("reset_rd1", rd1, 32'd0);
      chk("reset_rbusy2", {31'd0, rbusy2}, 32'd0);
    end
    chk("reset_collide", {31'd0, wr_collide}, 32'd0);

    // Single write with same-cycle bypass, then stored value
    next(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra0 = 5'd5; ra1 = 5'd6;
    #1; chk("bypass_w0", rd0, 32'hDEADBEEF);
    chk("bypass_other_addr", rd1, 32'd0);
    next(); idle();
    #1; chk("stored_w0", rd0, 32'hDEADBEEF);

    // Two writers on reg 7 for two cycles: port 0 wins, collision held then drops
    next(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra0 = 5'd7;
    #1; chk("prio_bypass", rd0, 32'h11);
    chk("collide_before_edge", {31'd0, wr_collide}, 32'd0);
    next();
    #1; chk("collide_first", {31'd0, wr_collide}, 32'd1);
    next(); idle();
    #1; chk("collide_back_to_back", {31'd0, wr_collide}, 32'd1);
    chk("prio_stored", rd0, 32'h11);
    next();
    #1; chk("collide_drops", {31'd0, wr_collide}, 32'd0);

    // Link save alone plus a load writeback to a different address
    next(); link_we = 1'b1; link_pc = 32'h00001000; we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h88;
    ra0 = 5'd31; ra1 = 5'd8;
    #1; chk("link_bypass", rd0, 32'h00001004);
    chk("w1_bypass_distinct", rd1, 32'h88);
    next(); idle();
    #1; chk("link_stored", rd0, 32'h00001004);
    chk("w1_stored_distinct", rd1, 32'h88);
    chk("no_collide_distinct", {31'd0, wr_collide}, 32'd0);

    // Load writeback outranks link save on reg 31
    next(); link_we = 1'b1; link_pc = 32'h00002000; we1 = 1'b1; wa1 = 5'd31; wd1 = 32'h5;
    #1; chk("link_vs_w1_bypass", rd0, 32'h5);
    next(); idle();
    #1; chk("link_vs_w1_stored", rd0, 32'h5);
    chk("link_collide", {31'd0, wr_collide}, 32'd1);

    // Link add wraps modulo 2^32
    next(); link_we = 1'b1; link_pc = 32'hFFFFFFFE;
    #1; chk("link_wrap", rd0, 32'h00000002);
    next(); idle();

    // Scoreboard: set, hold, clear by write, set beats clear
    next(); issue_v = 1'b1; issue_rd = 5'd3; ra2 = 5'd3;
    #1; chk("busy_not_bypassed", {31'd0, rbusy2}, 32'd0);
    next(); idle();
    #1; chk("busy_set", {31'd0, rbusy2}, 32'd1);
    next();
    #1; chk("busy_hold", {31'd0, rbusy2}, 32'd1);
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h33;
    #1; chk("busy_clear_pending", {31'd0, rbusy2}, 32'd1);
    next(); idle();
    #1; chk("busy_cleared", {31'd0, rbusy2}, 32'd0);
    chk("busy_reg_data", rd2, 32'h33);
    next(); issue_v = 1'b1; issue_rd = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h44;
    next(); idle();
    #1; chk("busy_set_wins", {31'd0, rbusy2}, 32'd1);
    chk("set_wins_data", rd2, 32'h44);

    // Register 0 is hardwired zero and never busy
    next(); we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF; issue_v = 1'b1; issue_rd = 5'd0; ra0 = 5'd0;
    #1; chk("r0_bypass_zero", rd0, 32'd0);
    next(); idle();
    #1; chk("r0_stored_zero", rd0, 32'd0);
    chk("r0_not_busy", {31'd0, rbusy0}, 32'd0);
    chk("r0_no_collide", {31'd0, wr_collide}, 32'd0);

    // Collision on register 0 still flags
    next(); we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1; we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h2;
    next(); idle();
    #1; chk("r0_collide", {31'd0, wr_collide}, 32'd1);
    chk("r0_still_zero", rd0, 32'd0);

    // Reset during a write to reg 9: bypass suppressed, write dropped, state cleared
    next(); rst = 1'b1; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; ra0 = 5'd9; ra1 = 5'd5;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h98;
    #1; chk("rst_no_bypass", rd0, 32'd0);
    next(); rst = 1'b0; idle();
    #1; chk("rst_drops_write", rd0, 32'd0);
    chk("rst_clears_array", rd1, 32'd0);
    chk("rst_clears_busy", {31'd0, rbusy2}, 32'd0);
    chk("rst_clears_collide", {31'd0, wr_collide}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

Parametrised multi-write-port register file for the terminal CPU core, successor of the single-write 16-entry file. Provides three combinational read ports with same-cycle write-to-read bypass, two prioritised writeback ports plus a link-register save path, and an optional hardwired-zero register 0. A per-register busy scoreboard lets issue logic detect pending writebacks. Sits between decode/issue and the ALU and load writeback stages.

## Interface
- AW, 5, address width; depth = 2^AW entries
- DW, 32, data width
- ZERO_R0, 1, 1 = register 0 reads 0, ignores writes, never busy
- LINK_REG, 2^AW-1, index written by the link save path
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ra0, ra1, ra2  in  AW  read addresses
- rd0, rd1, rd2  out  DW  read data (combinational, bypassed)
- rbusy0, rbusy1, rbusy2  out  1  busy bit of the addressed register
- we0, wa0, wd0  in  1/AW/DW  write port 0 (ALU writeback, highest priority)
- we1, wa1, wd1  in  1/AW/DW  write port 1 (load writeback)
- link_we  in  1  save PC+4 into LINK_REG
- link_pc  in  32  current PC
- issue_v  in  1  an instruction with destination issue_rd issues this cycle
- issue_rd  in  AW  destination register of issuing instruction
- wr_collide  out  1  registered pulse: previous cycle had two or more enabled writers on one address

## Operation
- Storage: 2^AW x DW array plus 2^AW busy bits; both updated only at clk rising edge.
- Link data: link_pc + 4, 32-bit modulo add, then truncated (DW<32) or zero-extended (DW>32) to DW.
- Write priority per target address: we0 > we1 > link_we. Exactly one value is stored per address per cycle; lower-priority writers to the same address are dropped.
- Different addresses written the same cycle all take effect.
- Bypass: rdN = value the array will hold for raN after this edge if any enabled writer targets raN (highest-priority writer selected); otherwise stored value.
- ZERO_R0=1: rdN = 0 when raN = 0, regardless of writers; writes and issue to register 0 are ignored; rbusyN = 0 for raN = 0.
- Scoreboard: issue_v sets busy[issue_rd]. Any accepted write (we0, we1 or link_we, after priority) to address a clears busy[a]. Set and clear on the same address in the same cycle: set wins (new producer outstanding).
- rbusyN = stored busy[raN]; no bypass of busy (set/clear visible next cycle).
- wr_collide: registered 1 if at the previous edge any two of {we0, we1, link_we} were enabled with equal target addresses (link target = LINK_REG); includes register 0 writes.
- Addresses are AW bits; no out-of-range case exists.

## Timing
- Read latency 0 (combinational from raN and write ports); write latency 1 edge.
- Reset: at a rising edge with rst=1 all entries clear to 0, all busy bits to 0, wr_collide to 0; all writes, link_we and issue_v in that cycle are ignored. Bypass is suppressed while rst=1, so rd0..rd2 read the cleared array (0 after the first reset edge).
- After reset: rd0..rd2 = 0, rbusy0..2 = 0, wr_collide = 0 until stimulus.
- rst asserted mid-operation discards any in-flight write at that edge; scoreboard state is lost (issue logic must be flushed alongside).
- wr_collide is high for exactly one cycle per colliding cycle; back-to-back collisions keep it high.

## Test plan
- Reset then read all addresses -> every rdN = 0, rbusyN = 0, wr_collide = 0.
- we0=1, wa0=5, wd0=0xDEADBEEF with ra0=5 same cycle -> rd0 = 0xDEADBEEF combinationally; next cycle with we0=0 -> rd0 still 0xDEADBEEF.
- we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 -> rd bypass and stored value 0x11; wr_collide = 1 the following cycle only.
- link_we=1, link_pc=0x00001000, LINK_REG=31, no other writers to 31 -> reg 31 = 0x00001004; with we1 wa1=31 wd1=0x5 same cycle -> reg 31 = 0x5, wr_collide = 1 next cycle.
- issue_v issue_rd=3 -> rbusy for ra=3 goes 1 next cycle; we1 wa1=3 later -> busy clears next cycle; issue_rd=3 and we0 wa0=3 same cycle -> busy stays 1.
- ZERO_R0=1: we0 wa0=0 wd0=0xFFFF, issue_rd=0 -> ra0=0 reads 0, rbusy0 = 0; rst=1 during a write to reg 9 -> reg 9 reads 0 afterwards.
